// File: rtl/floor_request_scheduler_if.sv
// Call/floor inputs and scheduler outputs shared between the elevator
// controller side (master) and the request scheduler (slave).
interface floor_request_scheduler_if;
    logic [2:0] call_btn;
    logic [1:0] cur_floor;
    logic       moving;
    logic [1:0] request;
    logic       door_open;
    logic [2:0] pending;
    logic       busy;

    modport master (
        output call_btn, cur_floor, moving,
        input  request, door_open, pending, busy
    );

    modport slave (
        input  call_btn, cur_floor, moving,
        output request, door_open, pending, busy
    );
endinterface

// File: rtl/floor_request_scheduler.sv
// Three-floor elevator call scheduler: latches calls, picks the nearest
// pending floor, holds the target while travelling and times the door.
module floor_request_scheduler #(
    parameter int DOOR_CYCLES = 4
) (
    input logic                      clk,
    input logic                      reset,
    floor_request_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TRAVEL, DOOR} state_e;

    localparam logic [3:0] DOOR_LOAD = 4'(DOOR_CYCLES);

    state_e     state_q, state_d;
    logic       dir_q, dir_d;
    logic [1:0] target_q, target_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] pending_q, pending_d;
    logic [1:0] request_q, request_d;
    logic       door_open_q, door_open_d;
    logic       busy_q, busy_d;

    logic       cur_valid;
    logic [2:0] cur_oh, tgt_oh, others, clr;
    logic       pick_valid;
    logic [1:0] pick;

    assign cur_valid = (bus.cur_floor != 2'b11);
    assign cur_oh    = 3'b001 << bus.cur_floor;
    assign tgt_oh    = 3'b001 << target_q;
    assign others    = pending_q & ~cur_oh;

    // Nearest other pending floor; the only tie is 0 vs 2 seen from floor 1.
    always_comb begin
        pick_valid = 1'b0;
        pick       = 2'd0;
        case (bus.cur_floor)
            2'd0: begin
                if (others[1])      begin pick_valid = 1'b1; pick = 2'd1; end
                else if (others[2]) begin pick_valid = 1'b1; pick = 2'd2; end
            end
            2'd1: begin
                if (others[0] && others[2]) begin
                    pick_valid = 1'b1;
                    pick       = dir_q ? 2'd2 : 2'd0;
                end
                else if (others[2]) begin pick_valid = 1'b1; pick = 2'd2; end
                else if (others[0]) begin pick_valid = 1'b1; pick = 2'd0; end
            end
            2'd2: begin
                if (others[1])      begin pick_valid = 1'b1; pick = 2'd1; end
                else if (others[0]) begin pick_valid = 1'b1; pick = 2'd0; end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        request_d = request_q;
        clr       = 3'b000;
        case (state_q)
            IDLE: begin
                request_d = cur_valid ? bus.cur_floor : 2'b00;
                if (cur_valid) begin
                    if (|(pending_q & cur_oh) && !bus.moving) begin
                        state_d  = DOOR;
                        target_d = bus.cur_floor;
                        cnt_d    = DOOR_LOAD;
                        clr      = cur_oh;
                    end else if (pick_valid) begin
                        state_d   = TRAVEL;
                        target_d  = pick;
                        request_d = pick;
                        dir_d     = (pick > bus.cur_floor);
                    end
                end
            end
            TRAVEL: begin
                if (bus.cur_floor == target_q && !bus.moving) begin
                    state_d = DOOR;
                    cnt_d   = DOOR_LOAD;
                    clr     = tgt_oh;
                end
            end
            DOOR: begin
                // A press for the open floor only keeps the door open longer.
                clr = tgt_oh;
                if (|(bus.call_btn & tgt_oh)) begin
                    cnt_d = DOOR_LOAD;
                end else if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        pending_d   = (pending_q | bus.call_btn) & ~clr;
        door_open_d = (state_d == DOOR);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= 1'b1;
            target_q    <= 2'd0;
            cnt_q       <= 4'd0;
            pending_q   <= 3'b000;
            request_q   <= 2'b00;
            door_open_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            request_q   <= request_d;
            door_open_q <= door_open_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.request   = request_q;
    assign bus.door_open = door_open_q;
    assign bus.pending   = pending_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/floor_request_scheduler.md
FLOOR_REQUEST_SCHEDULER -- requirements
Module: floor_request_scheduler

Interface
REQ-001 SHALL have parameter DOOR_CYCLES, default 4, meaning number of cycles door_open stays high per stop (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port call_btn  input  3  per-floor call buttons, bit i = floor i, level or pulse, sampled every cycle.
REQ-005 SHALL have port cur_floor  input  2  current floor from the elevator controller (00/01/10; 11 invalid).
REQ-006 SHALL have port moving  input  1  controller moving flag.
REQ-007 SHALL have port request  output  2  target floor code driven to the controller (00 floor 0, 01 floor 1, 10 floor 2).
REQ-008 SHALL have port door_open  output  1  door-open indication.
REQ-009 SHALL have port pending  output  3  latched outstanding calls, bit i = floor i.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL register all outputs; no combinational input-to-output path.
REQ-012 SHALL set pending[i] the cycle after call_btn[i] is sampled high; bits stay set until served; simultaneous presses all latch.
REQ-013 SHALL implement states IDLE, TRAVEL, DOOR plus a direction register dir (1 = up).
REQ-014 IDLE, pending empty: SHALL hold request = cur_floor code (00 if cur_floor invalid), door_open 0, stay IDLE.
REQ-015 IDLE, pending[cur_floor] set and moving 0: SHALL go to DOOR next cycle, clear that pending bit, load door counter with DOOR_CYCLES.
REQ-016 IDLE, other pending only: SHALL select target = nearest pending floor by |floor - cur_floor|; tie (at floor 1, floors 0 and 2 both pending) resolves by dir, up -> floor 2, down -> floor 0.
REQ-017 On target selection SHALL drive request = target code from the next cycle, set dir = (target > cur_floor), enter TRAVEL.
REQ-018 TRAVEL: SHALL hold request and target stable; new presses only latch into pending, no re-targeting.
REQ-019 TRAVEL: arrival = cur_floor == target and moving == 0 in the same sampled cycle; on arrival SHALL enter DOOR, clear pending[target], load counter.
REQ-020 DOOR: door_open SHALL be 1 for exactly DOOR_CYCLES consecutive cycles, then state returns to IDLE with door_open 0.
REQ-021 DOOR: call_btn for the door floor SHALL reload the counter to DOOR_CYCLES and not set pending; request held at door floor code.
REQ-022 Clear-and-press same bit same cycle: clear wins if it is the door floor (per REQ-021); presses for other floors always latch.
REQ-023 cur_floor == 11: SHALL not dispatch or enter DOOR; request 00; pending still latches; TRAVEL continues waiting.
REQ-024 Latency: press at cycle n with IDLE and distinct floor -> pending at n+1, request updated and busy 1 at n+2.
REQ-025 SHALL use a 4-bit door counter; no wrap-around permitted (saturates at 0).

Reset
REQ-026 On reset high at clock edge SHALL force state IDLE, request 00, door_open 0, pending 000, busy 0, dir 1, counter 0, regardless of state (including mid-TRAVEL or mid-DOOR).
REQ-027 Presses sampled during reset SHALL be discarded.

Verification
REQ-028 Reset, cur_floor 00, press call_btn 100 one cycle -> pending 100 next cycle, request 10 and busy 1 one cycle later; cur_floor 10 moving 0 -> door_open 1 for 4 cycles, pending 000, then IDLE.
REQ-029 At floor 01 IDLE, dir up, press 101 together -> target floor 2 (request 10); after its DOOR, target floor 0 (request 00).
REQ-030 At floor 00 IDLE, press 001 -> DOOR immediately (no TRAVEL), door_open 4 cycles, request stays 00.
REQ-031 During DOOR at floor 2, press call_btn 100 at count 1 -> door_open extended to 4 more cycles, pending[2] stays 0.
REQ-032 Mid-TRAVEL to floor 2, press 010 -> request stays 10 until arrival; floor 1 served afterward.
REQ-033 Assert reset during DOOR with pending 011 -> next cycle all outputs at reset values.
